// File: rtl/frame_buffer_reader_if.sv
// Frame buffer read side bundle: buffer read port plus the VGA connector.
//   addr_out    - buffer read address (reader -> buffer)
//   data_in     - buffer read data, one clock after addr_out (buffer -> reader)
//   vga_rgb     - RGB332 pixel to the DAC
//   hsync/vsync - active-low sync pulses
//   de          - display enable, high on active pixels
//   frame_start - one-clock pulse aligned with output pixel (0,0)
// The master modport is the reader; the slave modport is the buffer/connector side.
interface frame_buffer_reader_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_in;
  logic [DW-1:0] vga_rgb;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic          frame_start;

  modport master (
    output addr_out, vga_rgb, hsync, vsync, de, frame_start,
    input  data_in
  );

  modport slave (
    input  addr_out, vga_rgb, hsync, vsync, de, frame_start,
    output data_in
  );
endinterface

// File: rtl/frame_buffer_reader.sv
// Read-side controller for the dual-port frame buffer.
// Generates VGA timing from the pixel clock, scans the stored image upscaled
// by pixel/line replication (2**SCALE_SH in both axes) and registers the
// returned pixel into the VGA output. Sync, enable and frame_start travel
// alongside the pixel so every output is registered and mutually aligned,
// three clocks after the counters reach the corresponding position.
// Ports:
//   clk - pixel clock, also clocks the buffer read port
//   rst - asynchronous reset, active-low
//   bus - frame_buffer_reader_if.master (buffer read port + VGA outputs)
module frame_buffer_reader #(
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int SCALE_SH = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  frame_buffer_reader_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  // Stored-image column/row index widths; indices outside the active area
  // may truncate but their address is forced to zero anyway.
  localparam int CW      = $clog2(IMG_W);
  localparam int RW      = $clog2(IMG_H);

  localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  logic          act_p0, hs_p0, vs_p0, fs_p0;
  logic [CW-1:0] col_p0;
  logic [RW-1:0] row_p0;
  logic [AW-1:0] addr_p0;

  logic [AW-1:0] addr_p1_q, addr_p1_d;
  logic          act_p1_q, act_p1_d;
  logic          hs_p1_q, hs_p1_d;
  logic          vs_p1_q, vs_p1_d;
  logic          fs_p1_q, fs_p1_d;

  logic          act_p2_q, act_p2_d;
  logic          hs_p2_q, hs_p2_d;
  logic          vs_p2_q, vs_p2_d;
  logic          fs_p2_q, fs_p2_d;

  logic [DW-1:0] rgb_p3_q, rgb_p3_d;
  logic          de_p3_q, de_p3_d;
  logic          hsync_p3_q, hsync_p3_d;
  logic          vsync_p3_q, vsync_p3_d;
  logic          fs_p3_q, fs_p3_d;

  always_comb begin
    // Stage 0: raster counters and position decode
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_MAX) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + VW'(1);
    end

    act_p0  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_p0   = !((h_cnt_q >= H_SS) && (h_cnt_q < H_SE));
    vs_p0   = !((v_cnt_q >= V_SS) && (v_cnt_q < V_SE));
    fs_p0   = (h_cnt_q == '0) && (v_cnt_q == '0);
    col_p0  = CW'(h_cnt_q >> SCALE_SH);
    row_p0  = RW'(v_cnt_q >> SCALE_SH);
    // Dropping the low SCALE_SH bits is what replicates pixels and lines.
    addr_p0 = AW'(row_p0) * AW'(IMG_W) + AW'(col_p0);

    // Stage 1: buffer address issued, control copied
    addr_p1_d = act_p0 ? addr_p0 : '0;
    act_p1_d  = act_p0;
    hs_p1_d   = hs_p0;
    vs_p1_d   = vs_p0;
    fs_p1_d   = fs_p0;

    // Stage 2: buffer returns data_in; control delayed to match
    act_p2_d  = act_p1_q;
    hs_p2_d   = hs_p1_q;
    vs_p2_d   = vs_p1_q;
    fs_p2_d   = fs_p1_q;

    // Stage 3: registered VGA outputs; blanking never shows RAM contents
    rgb_p3_d   = act_p2_q ? bus.data_in : '0;
    de_p3_d    = act_p2_q;
    hsync_p3_d = hs_p2_q;
    vsync_p3_d = vs_p2_q;
    fs_p3_d    = fs_p2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      addr_p1_q  <= '0;
      act_p1_q   <= 1'b0;
      hs_p1_q    <= 1'b1;
      vs_p1_q    <= 1'b1;
      fs_p1_q    <= 1'b0;
      act_p2_q   <= 1'b0;
      hs_p2_q    <= 1'b1;
      vs_p2_q    <= 1'b1;
      fs_p2_q    <= 1'b0;
      rgb_p3_q   <= '0;
      de_p3_q    <= 1'b0;
      hsync_p3_q <= 1'b1;
      vsync_p3_q <= 1'b1;
      fs_p3_q    <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      addr_p1_q  <= addr_p1_d;
      act_p1_q   <= act_p1_d;
      hs_p1_q    <= hs_p1_d;
      vs_p1_q    <= vs_p1_d;
      fs_p1_q    <= fs_p1_d;
      act_p2_q   <= act_p2_d;
      hs_p2_q    <= hs_p2_d;
      vs_p2_q    <= vs_p2_d;
      fs_p2_q    <= fs_p2_d;
      rgb_p3_q   <= rgb_p3_d;
      de_p3_q    <= de_p3_d;
      hsync_p3_q <= hsync_p3_d;
      vsync_p3_q <= vsync_p3_d;
      fs_p3_q    <= fs_p3_d;
    end
  end

  assign bus.addr_out    = addr_p1_q;
  assign bus.vga_rgb     = rgb_p3_q;
  assign bus.de          = de_p3_q;
  assign bus.hsync       = hsync_p3_q;
  assign bus.vsync       = vsync_p3_q;
  assign bus.frame_start = fs_p3_q;

endmodule
